// File: rtl/axi_wr_pkg.sv
// Shared types and constants for the write-channel router: FSM states, grant encodings,
// grant_id field positions, slave indices and BRESP codes.
package axi_wr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_RESP = 2'b11
    } wr_state_e;

    localparam logic [1:0] GS_IDLE = 2'b00;
    localparam logic [1:0] GS_M0   = 2'b01;
    localparam logic [1:0] GS_M1   = 2'b10;

    localparam int GID_MST_BIT = 3;
    localparam int GID_SLV_MSB = 2;
    localparam int GID_SLV_LSB = 0;

    localparam logic [2:0] S_ROM     = 3'd0;
    localparam logic [2:0] S_IM      = 3'd1;
    localparam logic [2:0] S_DM      = 3'd2;
    localparam logic [2:0] S_SENSOR  = 3'd3;
    localparam logic [2:0] S_DRAM    = 3'd4;
    localparam logic [2:0] S_DEFAULT = 3'd5;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_DECERR = 2'b11;

    // 2'b11 is illegal and is deliberately folded into "no grant".
    function automatic logic is_grant(input logic [1:0] gs);
        return (gs == GS_M0) || (gs == GS_M1);
    endfunction

endpackage

// File: rtl/axi_default_slave_wr.sv
// DECERR responder for unmapped write addresses: accepts AW and W while enabled,
// remembers the AWID and answers with DECERR until the master takes the response.
module axi_default_slave_wr
    import axi_wr_pkg::*;
#(
    parameter int IDW = 4
) (
    input  logic           ACLK,
    input  logic           ARESETn,
    input  logic           aw_en,
    input  logic           w_en,
    input  logic           b_en,
    input  logic           awvalid,
    input  logic [IDW-1:0] awid,
    output logic           awready,
    output logic           wready,
    output logic           bvalid,
    output logic [IDW-1:0] bid,
    output logic [1:0]     bresp
);

    logic [IDW-1:0] id_q;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            id_q <= '0;
        end else if (aw_en && awvalid) begin
            id_q <= awid;
        end
    end

    // b_en stays high for the whole response phase, so BVALID holds until BREADY.
    assign awready = aw_en;
    assign wready  = w_en;
    assign bvalid  = b_en;
    assign bid     = id_q;
    assign bresp   = BRESP_DECERR;

endmodule

// File: rtl/axi_write_router.sv
// Routes one AW/W/B write transaction at a time between the granted master and the
// selected slave, with an internal DECERR slave behind decode misses.
//
// state   | meaning
// IDLE    | waiting for an M0/M1 grant; routing indices latched on exit
// ADDR    | AW forwarded master->slave; W held off
// DATA    | W forwarded; beats counted against AWLEN until WLAST
// RESP    | B forwarded slave->master; xfer_done on the handshake
module axi_write_router
    import axi_wr_pkg::*;
#(
    parameter int NM   = 2,
    parameter int NS   = 5,
    parameter int IDW  = 4,
    parameter int SIDW = 8,
    parameter int AW   = 32,
    parameter int DW   = 32
) (
    input  logic                 ACLK,
    input  logic                 ARESETn,
    input  logic [1:0]           grant_state,
    input  logic [3:0]           grant_id,
    input  logic [NM*IDW-1:0]    m_awid,
    input  logic [NM*AW-1:0]     m_awaddr,
    input  logic [NM*4-1:0]      m_awlen,
    input  logic [NM*3-1:0]      m_awsize,
    input  logic [NM*2-1:0]      m_awburst,
    input  logic [NM-1:0]        m_awvalid,
    output logic [NM-1:0]        m_awready,
    input  logic [NM*DW-1:0]     m_wdata,
    input  logic [NM*DW/8-1:0]   m_wstrb,
    input  logic [NM-1:0]        m_wlast,
    input  logic [NM-1:0]        m_wvalid,
    output logic [NM-1:0]        m_wready,
    output logic [NM*IDW-1:0]    m_bid,
    output logic [NM*2-1:0]      m_bresp,
    output logic [NM-1:0]        m_bvalid,
    input  logic [NM-1:0]        m_bready,
    output logic [NS*SIDW-1:0]   s_awid,
    output logic [NS*AW-1:0]     s_awaddr,
    output logic [NS*4-1:0]      s_awlen,
    output logic [NS*3-1:0]      s_awsize,
    output logic [NS*2-1:0]      s_awburst,
    output logic [NS-1:0]        s_awvalid,
    input  logic [NS-1:0]        s_awready,
    output logic [NS*DW-1:0]     s_wdata,
    output logic [NS*DW/8-1:0]   s_wstrb,
    output logic [NS-1:0]        s_wlast,
    output logic [NS-1:0]        s_wvalid,
    input  logic [NS-1:0]        s_wready,
    input  logic [NS*SIDW-1:0]   s_bid,
    input  logic [NS*2-1:0]      s_bresp,
    input  logic [NS-1:0]        s_bvalid,
    output logic [NS-1:0]        s_bready,
    output logic                 xfer_done,
    output logic                 wlast_err
);

    localparam int SW = DW / 8;

    wr_state_e      state, state_nxt;
    logic           mst_q;
    logic [2:0]     slv_q;
    logic [3:0]     awlen_q;
    logic [3:0]     beat_q;
    logic           wlast_err_q;

    logic           def_sel;
    logic [2:0]     sidx;
    int             mi, si;

    logic           sel_awvalid, sel_wvalid, sel_wlast, sel_bready;
    logic [IDW-1:0] sel_awid;
    logic [3:0]     sel_awlen;
    logic           sel_s_awready, sel_s_wready, sel_s_bvalid;
    logic           aw_hs, w_hs, b_hs;

    logic           ds_awready, ds_wready, ds_bvalid;
    logic [IDW-1:0] ds_bid;
    logic [1:0]     ds_bresp;

    // sidx is clamped so that a decode miss never indexes past the real slaves.
    assign def_sel = (slv_q >= S_DEFAULT);
    assign sidx    = def_sel ? 3'd0 : slv_q;

    always_comb begin
        mi = int'(mst_q);
        si = int'(sidx);
    end

    assign sel_awvalid = m_awvalid[mst_q];
    assign sel_awid    = m_awid[mi*IDW +: IDW];
    assign sel_awlen   = m_awlen[mi*4 +: 4];
    assign sel_wvalid  = m_wvalid[mst_q];
    assign sel_wlast   = m_wlast[mst_q];
    assign sel_bready  = m_bready[mst_q];

    assign sel_s_awready = def_sel ? ds_awready : s_awready[sidx];
    assign sel_s_wready  = def_sel ? ds_wready  : s_wready[sidx];
    assign sel_s_bvalid  = def_sel ? ds_bvalid  : s_bvalid[sidx];

    assign aw_hs = (state == ST_ADDR) && sel_awvalid && sel_s_awready;
    assign w_hs  = (state == ST_DATA) && sel_wvalid  && sel_s_wready;
    assign b_hs  = (state == ST_RESP) && sel_s_bvalid && sel_bready;

    axi_default_slave_wr #(.IDW(IDW)) u_default_slave (
        .ACLK    (ACLK),
        .ARESETn (ARESETn),
        .aw_en   ((state == ST_ADDR) && def_sel),
        .w_en    ((state == ST_DATA) && def_sel),
        .b_en    ((state == ST_RESP) && def_sel),
        .awvalid (sel_awvalid),
        .awid    (sel_awid),
        .awready (ds_awready),
        .wready  (ds_wready),
        .bvalid  (ds_bvalid),
        .bid     (ds_bid),
        .bresp   (ds_bresp)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (is_grant(grant_state)) state_nxt = ST_ADDR;
            ST_ADDR: if (aw_hs)                 state_nxt = ST_DATA;
            ST_DATA: if (w_hs && sel_wlast)     state_nxt = ST_RESP;
            ST_RESP: if (b_hs)                  state_nxt = ST_IDLE;
            default:                            state_nxt = ST_IDLE;
        endcase
    end

    // Grant inputs are only looked at in IDLE; everything after uses the latched indices.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            mst_q       <= 1'b0;
            slv_q       <= 3'd0;
            awlen_q     <= 4'd0;
            beat_q      <= 4'd0;
            wlast_err_q <= 1'b0;
        end else begin
            if (state == ST_IDLE && is_grant(grant_state)) begin
                mst_q <= grant_id[GID_MST_BIT];
                slv_q <= grant_id[GID_SLV_MSB:GID_SLV_LSB];
            end
            if (aw_hs) begin
                awlen_q <= sel_awlen;
                beat_q  <= 4'd0;
            end
            if (w_hs) begin
                beat_q <= beat_q + 4'd1;
                if (sel_wlast != (beat_q == awlen_q)) begin
                    wlast_err_q <= 1'b1;
                end
            end
        end
    end

    assign wlast_err = wlast_err_q;

    always_comb begin
        m_awready = '0;
        m_wready  = '0;
        m_bvalid  = '0;
        m_bid     = '0;
        m_bresp   = '0;
        s_awid    = '0;
        s_awaddr  = '0;
        s_awlen   = '0;
        s_awsize  = '0;
        s_awburst = '0;
        s_awvalid = '0;
        s_wdata   = '0;
        s_wstrb   = '0;
        s_wlast   = '0;
        s_wvalid  = '0;
        s_bready  = '0;
        xfer_done = 1'b0;
        case (state)
            ST_ADDR: begin
                m_awready[mst_q] = sel_s_awready;
                if (!def_sel) begin
                    s_awvalid[sidx]            = sel_awvalid;
                    s_awid[si*SIDW +: SIDW]    = {{(SIDW-IDW-1){1'b0}}, mst_q, sel_awid};
                    s_awaddr[si*AW +: AW]      = m_awaddr[mi*AW +: AW];
                    s_awlen[si*4 +: 4]         = sel_awlen;
                    s_awsize[si*3 +: 3]        = m_awsize[mi*3 +: 3];
                    s_awburst[si*2 +: 2]       = m_awburst[mi*2 +: 2];
                end
            end
            ST_DATA: begin
                m_wready[mst_q] = sel_s_wready;
                if (!def_sel) begin
                    s_wvalid[sidx]        = sel_wvalid;
                    s_wdata[si*DW +: DW]  = m_wdata[mi*DW +: DW];
                    s_wstrb[si*SW +: SW]  = m_wstrb[mi*SW +: SW];
                    s_wlast[sidx]         = sel_wlast;
                end
            end
            ST_RESP: begin
                m_bvalid[mst_q]         = sel_s_bvalid;
                m_bid[mi*IDW +: IDW]    = def_sel ? ds_bid   : s_bid[si*SIDW +: IDW];
                m_bresp[mi*2 +: 2]      = def_sel ? ds_bresp : s_bresp[si*2 +: 2];
                if (!def_sel) begin
                    s_bready[sidx] = sel_bready;
                end
                xfer_done = b_hs;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_axi_write_router.sv
// Directed scoreboard bench for axi_write_router: W beats and B responses are queued as
// they are driven and checked where the DUT hands them over.
module tb_axi_write_router;
    import axi_wr_pkg::*;

    localparam int NM = 2, NS = 5, IDW = 4, SIDW = 8, AW = 32, DW = 32;

    logic ACLK = 1'b0;
    logic ARESETn;
    logic [1:0]         grant_state;
    logic [3:0]         grant_id;
    logic [NM*IDW-1:0]  m_awid;
    logic [NM*AW-1:0]   m_awaddr;
    logic [NM*4-1:0]    m_awlen;
    logic [NM*3-1:0]    m_awsize;
    logic [NM*2-1:0]    m_awburst;
    logic [NM-1:0]      m_awvalid, m_awready;
    logic [NM*DW-1:0]   m_wdata;
    logic [NM*DW/8-1:0] m_wstrb;
    logic [NM-1:0]      m_wlast, m_wvalid, m_wready;
    logic [NM*IDW-1:0]  m_bid;
    logic [NM*2-1:0]    m_bresp;
    logic [NM-1:0]      m_bvalid, m_bready;
    logic [NS*SIDW-1:0] s_awid;
    logic [NS*AW-1:0]   s_awaddr;
    logic [NS*4-1:0]    s_awlen;
    logic [NS*3-1:0]    s_awsize;
    logic [NS*2-1:0]    s_awburst;
    logic [NS-1:0]      s_awvalid, s_awready;
    logic [NS*DW-1:0]   s_wdata;
    logic [NS*DW/8-1:0] s_wstrb;
    logic [NS-1:0]      s_wlast, s_wvalid, s_wready;
    logic [NS*SIDW-1:0] s_bid;
    logic [NS*2-1:0]    s_bresp;
    logic [NS-1:0]      s_bvalid, s_bready;
    logic               xfer_done, wlast_err;

    always #5 ACLK = ~ACLK;

    axi_write_router #(.NM(NM), .NS(NS), .IDW(IDW), .SIDW(SIDW), .AW(AW), .DW(DW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .grant_state(grant_state), .grant_id(grant_id),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
        .m_wready(m_wready), .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid),
        .m_bready(m_bready), .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awlen(s_awlen),
        .s_awsize(s_awsize), .s_awburst(s_awburst), .s_awvalid(s_awvalid),
        .s_awready(s_awready), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_bid(s_bid), .s_bresp(s_bresp),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .xfer_done(xfer_done), .wlast_err(wlast_err)
    );

    typedef struct { logic [31:0] data; logic last; } wbeat_t;
    typedef struct { logic [3:0] bid; logic [1:0] bresp; } bexp_t;

    wbeat_t wq[$];
    bexp_t  bq[$];
    wbeat_t mon_w;
    bexp_t  mon_b;
    logic   mon_hs;
    int n_chk = 0, n_fail = 0;
    int exp_m = 0, exp_slv = 7, beats_seen = 0, xfer_cnt = 0;
    bit active = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Handshakes observed just before the edge that completes them.
    always @(negedge ACLK) begin
        #2;
        if (ARESETn) begin
            chk("xfer_done_vs_bhs", xfer_done, |(m_bvalid & m_bready));
            if (xfer_done) xfer_cnt++;
            for (int j = 0; j < NS; j++)
                if (j != exp_slv) chk("slave_isolation", {s_awvalid[j], s_wvalid[j], s_bready[j]}, 3'b000);
            if (active) begin
                chk("master_isolation", {m_awready[1-exp_m], m_wready[1-exp_m], m_bvalid[1-exp_m]}, 3'b000);
                if (exp_slv < NS) mon_hs = s_wvalid[exp_slv] & s_wready[exp_slv];
                else              mon_hs = m_wvalid[exp_m] & m_wready[exp_m];
                if (mon_hs) begin
                    chk("w_queue_nonempty", wq.size() != 0, 1);
                    if (wq.size() != 0) begin
                        mon_w = wq.pop_front();
                        beats_seen++;
                        if (exp_slv < NS) begin
                            chk("s_wdata", s_wdata[exp_slv*DW +: DW], mon_w.data);
                            chk("s_wlast", s_wlast[exp_slv], mon_w.last);
                        end
                    end
                end
                if (m_bvalid[exp_m] && m_bready[exp_m]) begin
                    chk("b_queue_nonempty", bq.size() != 0, 1);
                    if (bq.size() != 0) begin
                        mon_b = bq.pop_front();
                        chk("m_bid", m_bid[exp_m*IDW +: IDW], mon_b.bid);
                        chk("m_bresp", m_bresp[exp_m*2 +: 2], mon_b.bresp);
                    end
                end
            end
        end
    end

    task automatic write_txn(input int m, input logic [3:0] gid, input logic [3:0] id,
                             input logic [31:0] addr, input logic [3:0] len, input int last_beat,
                             input logic [31:0] dbase, input int wstall, input int bdelay,
                             input int bstall, input bit glitch, input int rst_at);
        int s, x0;
        bit real_s;
        logic [SIDW-1:0] cap_awid;
        wbeat_t wb;
        bexp_t be;
        s = int'(gid[2:0]);
        real_s = (s < NS);
        x0 = xfer_cnt;
        cap_awid = '0;
        beats_seen = 0;
        exp_m = m; exp_slv = s; active = 1'b1;
        @(negedge ACLK);
        grant_state = (m == 1) ? GS_M1 : GS_M0; grant_id = gid;
        @(negedge ACLK);
        grant_state = GS_IDLE; grant_id = 4'h0;
        m_awid[m*IDW +: IDW] = id; m_awaddr[m*AW +: AW] = addr; m_awlen[m*4 +: 4] = len;
        m_awsize[m*3 +: 3] = 3'd2; m_awburst[m*2 +: 2] = 2'b01; m_awvalid[m] = 1'b1;
        // First beat is offered early: it must wait for the AW handshake.
        wb.data = dbase; wb.last = (last_beat == 0); wq.push_back(wb);
        m_wdata[m*DW +: DW] = dbase; m_wstrb[m*4 +: 4] = 4'hF; m_wlast[m] = wb.last; m_wvalid[m] = 1'b1;
        be.bid = id; be.bresp = real_s ? BRESP_OKAY : BRESP_DECERR; bq.push_back(be);
        if (real_s) begin s_awready[s] = 1'b1; s_wready[s] = 1'b1; end
        #1;
        chk("m_awready", m_awready[m], 1);
        chk("m_wready_in_addr", m_wready[m], 0);
        if (real_s) begin
            chk("s_awvalid", s_awvalid[s], 1);
            chk("s_awaddr", s_awaddr[s*AW +: AW], addr);
            chk("s_awid", s_awid[s*SIDW +: SIDW], {3'b000, 1'(m), id});
            chk("s_awlen", s_awlen[s*4 +: 4], len);
            cap_awid = s_awid[s*SIDW +: SIDW];
        end
        @(negedge ACLK);
        m_awvalid[m] = 1'b0;
        if (real_s) s_awready[s] = 1'b0;
        for (int b = 0; b <= last_beat; b++) begin
            if (b > 0) begin
                wb.data = dbase + b; wb.last = (b == last_beat); wq.push_back(wb);
                m_wdata[m*DW +: DW] = wb.data; m_wlast[m] = wb.last;
            end
            if (glitch && b == 1) begin grant_state = GS_M1; grant_id = {1'b1, S_DRAM}; end
            if (rst_at == b) begin
                if (real_s) s_wready[s] = 1'b0;
                #1 ARESETn = 1'b0;
                #1;
                chk("rst_valid_ready_zero",
                    {m_awready, m_wready, m_bvalid, s_awvalid, s_wvalid, s_bready, xfer_done}, 0);
                @(negedge ACLK);
                ARESETn = 1'b1;
                m_wvalid = '0; m_wlast = '0; wq.delete(); bq.delete();
                active = 1'b0; exp_slv = 7;
                return;
            end
            if (real_s && b == 0 && wstall > 0) begin
                s_wready[s] = 1'b0;
                repeat (wstall) begin
                    #1;
                    chk("m_wready_stalled", m_wready[m], 0);
                    chk("s_wvalid_stalled", s_wvalid[s], 1);
                    @(negedge ACLK);
                end
            end
            if (real_s) s_wready[s] = 1'b1;
            #1;
            chk("m_wready", m_wready[m], 1);
            if (glitch) chk("s_wvalid_route", s_wvalid[s], 1);
            @(negedge ACLK);
        end
        m_wvalid[m] = 1'b0; m_wlast[m] = 1'b0; grant_state = GS_IDLE; grant_id = 4'h0;
        if (real_s) begin
            s_wready[s] = 1'b0;
            repeat (bdelay) begin
                #1 chk("m_bvalid_before_slave", m_bvalid[m], 0);
                @(negedge ACLK);
            end
            s_bvalid[s] = 1'b1; s_bid[s*SIDW +: SIDW] = cap_awid; s_bresp[s*2 +: 2] = BRESP_OKAY;
        end
        repeat (bstall) begin
            #1;
            chk("m_bvalid_held", m_bvalid[m], 1);
            chk("xfer_done_early", xfer_done, 0);
            @(negedge ACLK);
        end
        // A grant presented in the completion cycle must not be taken.
        m_bready[m] = 1'b1; grant_state = (m == 1) ? GS_M1 : GS_M0; grant_id = gid;
        #1;
        chk("m_bvalid", m_bvalid[m], 1);
        if (real_s) chk("s_bready", s_bready[s], 1);
        @(negedge ACLK);
        m_bready[m] = 1'b0; grant_state = GS_IDLE; grant_id = 4'h0;
        if (real_s) s_bvalid[s] = 1'b0;
        m_awvalid[m] = 1'b1;
        #1;
        chk("idle_no_aw_forward", |s_awvalid, 0);
        chk("idle_no_awready", m_awready[m], 0);
        chk("beats_delivered", beats_seen, last_beat + 1);
        chk("w_queue_drained", wq.size(), 0);
        chk("b_queue_drained", bq.size(), 0);
        chk("xfer_done_pulses", xfer_cnt - x0, 1);
        @(negedge ACLK);
        m_awvalid[m] = 1'b0; active = 1'b0; exp_slv = 7;
    endtask

    initial begin
        ARESETn = 1'b0; grant_state = GS_IDLE; grant_id = 4'h0;
        m_awid = '0; m_awaddr = '0; m_awlen = '0; m_awsize = '0; m_awburst = '0; m_awvalid = '0;
        m_wdata = '0; m_wstrb = '0; m_wlast = '0; m_wvalid = '0; m_bready = '0;
        s_awready = '0; s_wready = '0; s_bid = '0; s_bresp = '0; s_bvalid = '0;
        repeat (3) @(negedge ACLK);
        #1;
        chk("reset_handshakes_zero",
            {m_awready, m_wready, m_bvalid, s_awvalid, s_wvalid, s_bready, xfer_done}, 0);
        chk("reset_payload_zero", |{s_awid, s_awaddr, s_awlen, s_wdata, s_wstrb, s_wlast, m_bid, m_bresp}, 0);
        chk("reset_wlast_err", wlast_err, 0);
        @(negedge ACLK);
        ARESETn = 1'b1;

        write_txn(0, {1'b0, S_DM}, 4'h5, 32'h0002_0010, 4'd0, 0, 32'hDEAD_BEEF, 0, 0, 0, 1'b0, -1);
        chk("wlast_err_single", wlast_err, 0);

        write_txn(1, {1'b1, S_DRAM}, 4'hA, 32'h8000_0100, 4'd3, 3, 32'h1000_0000, 0, 1, 0, 1'b0, -1);
        chk("wlast_err_burst", wlast_err, 0);

        write_txn(0, {1'b0, S_DEFAULT}, 4'h7, 32'hF000_0000, 4'd1, 1, 32'h5555_0000, 0, 0, 0, 1'b0, -1);
        chk("wlast_err_decerr", wlast_err, 0);

        write_txn(0, {1'b0, S_DM}, 4'h2, 32'h0002_0040, 4'd1, 1, 32'hCAFE_0000, 3, 5, 2, 1'b0, -1);
        chk("wlast_err_backpressure", wlast_err, 0);

        write_txn(0, {1'b0, S_DM}, 4'h9, 32'h0002_0080, 4'd3, 1, 32'hA5A5_0000, 0, 0, 0, 1'b1, -1);
        chk("wlast_err_set", wlast_err, 1);

        write_txn(1, {1'b1, S_ROM}, 4'h1, 32'h0000_0100, 4'd0, 0, 32'h0000_0001, 0, 0, 0, 1'b0, -1);
        chk("wlast_err_sticky", wlast_err, 1);

        write_txn(0, {1'b0, S_SENSOR}, 4'h3, 32'h4000_0000, 4'd3, 3, 32'hBEEF_0000, 0, 0, 0, 1'b0, 1);
        chk("wlast_err_after_reset", wlast_err, 0);

        write_txn(0, {1'b0, S_IM}, 4'h4, 32'h1000_0000, 4'd2, 2, 32'h7700_0000, 0, 0, 0, 1'b0, -1);
        chk("wlast_err_post_reset_txn", wlast_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_write_router.md
Name: axi_write_router

Overview:
- Write-channel datapath stage directly downstream of the write arbiter on the 2-master / 5-slave AXI bus.
- Consumes the arbiter's grant state and routing ID, latches them for one complete write transaction, and routes the AW, W and B channels between the granted master and the selected slave.
- Contains an internal default slave that answers unmapped addresses with DECERR.
- Raises a completion pulse so the arbiter can return to idle.

Parameters:
- NM, 2, number of masters.
- NS, 5, number of real slaves (S0 ROM, S1 IM, S2 DM, S3 sensor ctrl, S4 DRAM).
- IDW, 4, master-side AXI ID width.
- SIDW, 8, slave-side ID width = IDW + 4-bit master tag.
- AW, 32, address width.
- DW, 32, data width.

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  asynchronous active-low reset
- grant_state  in  2  arbiter state: 00 idle, 01 M0, 10 M1, 11 illegal
- grant_id  in  4  routing ID: [3] master index, [2:0] slave index 0..4, 5..7 = decode miss
- m_awid/m_awaddr/m_awlen/m_awsize/m_awburst  in  NM×(IDW/AW/4/3/2)  master AW payload, packed
- m_awvalid  in  NM; m_awready  out  NM
- m_wdata/m_wstrb/m_wlast  in  NM×(DW/DW/8/1); m_wvalid  in  NM; m_wready  out  NM
- m_bid  out  NM×IDW; m_bresp  out  NM×2; m_bvalid  out  NM; m_bready  in  NM
- s_awid  out  NS×SIDW; s_awaddr/len/size/burst  out  NS×(AW/4/3/2); s_awvalid  out  NS; s_awready  in  NS
- s_wdata/s_wstrb/s_wlast  out  NS×(DW/DW/8/1); s_wvalid  out  NS; s_wready  in  NS
- s_bid  in  NS×SIDW; s_bresp  in  NS×2; s_bvalid  in  NS; s_bready  out  NS
- xfer_done  out  1  one-cycle pulse on the B handshake
- wlast_err  out  1  sticky flag: WLAST disagrees with the latched AWLEN

Behaviour:
- Reset:
  - FSM goes to IDLE; latched master/slave index and AWID are cleared.
  - Beat counter = 0, wlast_err = 0.
  - All valid/ready outputs are 0; payload outputs are 0.
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE:
  - All handshake outputs are 0.
  - When grant_state is 01 or 10, latch mst = grant_id[3] and slv = grant_id[2:0], then go to ADDR.
  - grant_state 11 is treated as idle.
- ADDR:
  - Forward m_aw*[mst] to s_aw*[slv] combinationally, with zero latency.
  - s_awid = {3'b000, mst, m_awid}.
  - m_awready[mst] = s_awready[slv].
  - On the AW handshake, latch AWID and AWLEN, clear the beat counter, go to DATA.
- DATA:
  - Forward W combinationally: s_wvalid[slv] = m_wvalid[mst], m_wready[mst] = s_wready[slv].
  - Every W handshake increments the beat counter (4 bits).
  - The handshake with m_wlast = 1 moves to RESP.
  - If WLAST arrives while count != AWLEN, or count == AWLEN without WLAST, set wlast_err; the transfer still completes on WLAST.
  - W beats offered before the AW handshake are stalled: wready = 0 in ADDR.
- RESP:
  - m_bvalid[mst] = s_bvalid[slv]; m_bid = s_bid[IDW-1:0]; m_bresp = s_bresp[slv]; s_bready[slv] = m_bready[mst].
  - On the handshake, pulse xfer_done for one cycle and return to IDLE.
  - No new grant is accepted in that same cycle.
- Default slave (slv >= 5):
  - AWREADY = 1 and WREADY = 1 in their respective states; no real slave is driven.
  - In RESP: BVALID = 1, BRESP = 2'b11 (DECERR), BID = latched AWID; held until BREADY.
- Grant changes while not in IDLE are ignored; routing uses only the latched indices.
- Signals to non-selected masters and slaves are held at 0 at all times.
- Only one write transaction is in flight; there is no outstanding-transaction support.
- Asynchronous reset mid-transfer forces IDLE immediately. Slaves are expected to be reset by the same ARESETn.

Decomposition:
- Package axi_wr_pkg holds:
  - FSM state enum.
  - Grant-state constants (IDLE/M0/M1).
  - grant_id field positions; slave index constants S_ROM..S_DRAM and S_DEFAULT = 5.
  - BRESP constants OKAY = 2'b00, DECERR = 2'b11.
- Sub-module axi_default_slave_wr implements the DECERR responder: AW/W accept, ID latch, B generation.

Test Plan:
- M0 single write:
  - Stimulus: grant 01, grant_id 4'b0010, AWADDR 0x0002_0010, AWLEN 0, WDATA 0xDEADBEEF, WLAST.
  - Required: S2 sees AW then W; s_awid = 8'h0X carrying the M0 tag; M0 gets BRESP OKAY; xfer_done pulses exactly once.
- M1 burst to DRAM:
  - Stimulus: grant 10, grant_id 4'b1100, AWLEN 3, four beats with WLAST on beat 4.
  - Required: S4 receives exactly 4 beats; wlast_err stays 0; BID returned to M1 equals its AWID.
- Decode miss:
  - Stimulus: M0, grant_id 4'b0101, AWID 4'h7, AWLEN 1.
  - Required: two beats accepted with no slave touched; m_bresp[0] = 11; m_bid = 7.
- Backpressure:
  - Stimulus: S2 holds wready low 3 cycles, then bvalid is delayed 5 cycles, then M0 holds bready low 2 cycles.
  - Required: no beat lost or duplicated; xfer_done only on the final handshake.
- Grant glitch and WLAST mismatch:
  - Stimulus: grant_state toggles to 10 during DATA; WLAST arrives on beat 2 with AWLEN 3.
  - Required: routing stays on M0; wlast_err = 1 and is sticky; FSM returns to IDLE.
- Reset mid-DATA:
  - Stimulus: ARESETn low after beat 1.
  - Required: all valid/ready outputs are 0 that cycle; FSM in IDLE; next grant executes cleanly.
